// File: rtl/fetch_decode_pkg.sv
// ============================================================================
// fetch_decode_pkg : shared widths, control codes and RV32I encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_decode_pkg;

  localparam int INST_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int HOLD_W     = 3;

  localparam logic RST_LEVEL = 1'b1;
  localparam logic JUMP_YES  = 1'b1;
  localparam logic JUMP_NO   = 1'b0;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

endpackage

`default_nettype wire

// File: rtl/fetch_decode_gen_dff.sv
// ============================================================================
// gen_dff : enabled register with asynchronous load of a reset value
// Revision: 1.0
// ============================================================================
`default_nettype none

module gen_dff
  import fetch_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // i_rst_val must be a constant or a static strap while rst is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_LEVEL) begin
      o_q <= i_rst_val;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_decode.sv
// ============================================================================
// fetch_decode : PC generation, IF/ID pipeline register and RV32I decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0013,
  parameter int          XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       start_i,
  input  logic                  jump_flag_i,
  input  logic [XLEN-1:0]       jump_addr_i,
  input  logic [HOLD_W-1:0]     hold_flag_i,
  output logic [XLEN-1:0]       pc_o,
  input  logic [INST_W-1:0]     rom_inst_i,
  output logic [INST_W-1:0]     inst_o,
  output logic [XLEN-1:0]       inst_addr_o,
  output logic [REG_ADDR_W-1:0] reg1_raddr_o,
  output logic [REG_ADDR_W-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0]       reg1_rdata_i,
  input  logic [XLEN-1:0]       reg2_rdata_i,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  logic                     w_jump;
  logic                     w_bubble;
  logic                     w_pc_en;
  logic                     w_ifid_en;
  logic [XLEN-1:0]          w_pc;
  logic [XLEN-1:0]          w_pc_next;
  logic [INST_W+XLEN-1:0]   w_ifid_d;
  logic [INST_W+XLEN-1:0]   w_ifid_q;
  logic [INST_W+XLEN-1:0]   w_ifid_rst;

  assign w_jump    = (jump_flag_i == JUMP_YES);
  assign w_pc_en   = w_jump || (hold_flag_i == HOLD_NONE);
  assign w_pc_next = w_jump ? jump_addr_i : (w_pc + XLEN'(4));

  // Jump squashes the in-flight fetch even when a hold is also requested
  assign w_bubble   = w_jump || (hold_flag_i >= HOLD_IF);
  assign w_ifid_en  = w_jump || (hold_flag_i != HOLD_PC);
  assign w_ifid_rst = {RESET_INST, {XLEN{1'b0}}};
  assign w_ifid_d   = w_bubble ? w_ifid_rst : {rom_inst_i, w_pc};

  gen_dff #(.WIDTH(XLEN)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_pc_en),
    .i_rst_val (start_i),
    .i_d       (w_pc_next),
    .o_q       (w_pc)
  );

  gen_dff #(.WIDTH(INST_W + XLEN)) u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_ifid_en),
    .i_rst_val (w_ifid_rst),
    .i_d       (w_ifid_d),
    .o_q       (w_ifid_q)
  );

  assign pc_o        = w_pc;
  assign inst_o      = w_ifid_q[INST_W+XLEN-1:XLEN];
  assign inst_addr_o = w_ifid_q[XLEN-1:0];

  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [XLEN-1:0]       w_imm_i;
  logic [XLEN-1:0]       w_imm_s;
  logic [XLEN-1:0]       w_imm_u;
  logic                  w_we;

  assign w_opcode = inst_o[6:0];
  assign w_rd     = inst_o[11:7];
  assign w_rs1    = inst_o[19:15];
  assign w_rs2    = inst_o[24:20];
  assign w_imm_i  = XLEN'($signed(inst_o[31:20]));
  assign w_imm_s  = XLEN'($signed({inst_o[31:25], inst_o[11:7]}));
  assign w_imm_u  = XLEN'($signed({inst_o[31:12], 12'b0}));

  always_comb begin
    reg1_raddr_o = '0;
    reg2_raddr_o = '0;
    op1_o        = '0;
    op2_o        = '0;
    w_we         = 1'b0;
    case (w_opcode)
      OPC_LOAD, OPC_OPIMM: begin
        reg1_raddr_o = w_rs1;
        op1_o        = reg1_rdata_i;
        op2_o        = w_imm_i;
        w_we         = 1'b1;
      end
      OPC_OP: begin
        reg1_raddr_o = w_rs1;
        reg2_raddr_o = w_rs2;
        op1_o        = reg1_rdata_i;
        op2_o        = reg2_rdata_i;
        w_we         = 1'b1;
      end
      OPC_STORE: begin
        reg1_raddr_o = w_rs1;
        reg2_raddr_o = w_rs2;
        op1_o        = reg1_rdata_i;
        op2_o        = w_imm_s;
      end
      OPC_BRANCH: begin
        reg1_raddr_o = w_rs1;
        reg2_raddr_o = w_rs2;
        op1_o        = reg1_rdata_i;
        op2_o        = reg2_rdata_i;
      end
      OPC_LUI: begin
        op1_o = w_imm_u;
        w_we  = 1'b1;
      end
      OPC_AUIPC: begin
        op1_o = inst_addr_o;
        op2_o = w_imm_u;
        w_we  = 1'b1;
      end
      OPC_JAL: begin
        op1_o = inst_addr_o;
        op2_o = XLEN'(4);
        w_we  = 1'b1;
      end
      OPC_JALR: begin
        reg1_raddr_o = w_rs1;
        op1_o        = inst_addr_o;
        op2_o        = XLEN'(4);
        w_we         = 1'b1;
      end
      default: ;
    endcase
    // Decode stays silent while reset is held, regardless of register-file data
    if (rst == RST_LEVEL) begin
      reg1_raddr_o = '0;
      reg2_raddr_o = '0;
      op1_o        = '0;
      op2_o        = '0;
      w_we         = 1'b0;
    end
  end

  assign reg_we_o    = w_we && (w_rd != '0);
  assign reg_waddr_o = reg_we_o ? w_rd : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
// ============================================================================
// tb_fetch_decode : scoreboard bench for PC/IF-ID sequencing and decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic [31:0] pc_o;
  logic [31:0] rom_inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [4:0]  reg1_raddr_o;
  logic [4:0]  reg2_raddr_o;
  logic [31:0] reg1_rdata_i;
  logic [31:0] reg2_rdata_i;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_decode #(.RESET_INST(32'h0000_0013), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .pc_o         (pc_o),
    .rom_inst_i   (rom_inst_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .reg1_raddr_o (reg1_raddr_o),
    .reg2_raddr_o (reg2_raddr_o),
    .reg1_rdata_i (reg1_rdata_i),
    .reg2_rdata_i (reg2_rdata_i),
    .op1_o        (op1_o),
    .op2_o        (op2_o),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:63];
  assign rom_inst_i   = rom[pc_o[7:2]];
  // Register xN reads back the value N
  assign reg1_rdata_i = {27'b0, reg1_raddr_o};
  assign reg2_rdata_i = {27'b0, reg2_raddr_o};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_addr;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] boot);
    m_pc   = boot;
    m_inst = NOP;
    m_addr = 32'h0;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare
  task automatic step();
    exp_t e;
    if (jump_flag_i) begin
      e.pc = jump_addr_i; e.inst = NOP; e.addr = 32'h0;
    end else if (hold_flag_i >= 3'd2) begin
      e.pc = m_pc; e.inst = NOP; e.addr = 32'h0;
    end else if (hold_flag_i == 3'd1) begin
      e.pc = m_pc; e.inst = m_inst; e.addr = m_addr;
    end else begin
      e.pc = m_pc + 32'd4; e.inst = rom[m_pc[7:2]]; e.addr = m_pc;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("pc", pc_o, e.pc);
    check_val("inst", inst_o, e.inst);
    check_val("inst_addr", inst_addr_o, e.addr);
    m_pc = e.pc; m_inst = e.inst; m_addr = e.addr;
  endtask

  task automatic check_dec(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] o1, input logic [31:0] o2,
                           input logic we, input logic [4:0] wa);
    check_val({tag, ".raddr1"}, {27'b0, reg1_raddr_o}, {27'b0, r1});
    check_val({tag, ".raddr2"}, {27'b0, reg2_raddr_o}, {27'b0, r2});
    check_val({tag, ".op1"}, op1_o, o1);
    check_val({tag, ".op2"}, op2_o, o2);
    check_val({tag, ".we"}, {31'b0, reg_we_o}, {31'b0, we});
    check_val({tag, ".waddr"}, {27'b0, reg_waddr_o}, {27'b0, wa});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013 | (32'(i) << 20);
    rom[8'h20 >> 2] = 32'h0051_0093;  // addi x1,x2,5
    rom[8'h24 >> 2] = 32'h0020_81B3;  // add  x3,x1,x2
    rom[8'h28 >> 2] = 32'h0020_8463;  // beq  x1,x2
    rom[8'h2C >> 2] = 32'h1234_50B7;  // lui  x1
    rom[8'h30 >> 2] = 32'hFFF0_0013;  // addi x0,x0,-1
    rom[8'h34 >> 2] = 32'h0000_00EF;  // jal  x1,0
    rom[8'h38 >> 2] = 32'hFFFF_FFFF;  // unknown opcode

    rst = 1'b1; start_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc", pc_o, 32'h0);
    check_val("rst_inst", inst_o, NOP);
    check_val("rst_addr", inst_addr_o, 32'h0);
    check_dec("rst_dec", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);

    rst = 1'b0;
    model_reset(32'h0);
    repeat (4) step();
    check_val("run_pc_16", pc_o, 32'h10);

    hold_flag_i = 3'd1;
    repeat (2) step();
    check_val("hold_pc", pc_o, 32'h10);
    check_val("hold_inst", inst_o, rom[3]);
    hold_flag_i = 3'd0;
    step();
    check_val("release_pc", pc_o, 32'h14);

    hold_flag_i = 3'd2; step();
    hold_flag_i = 3'd3; step();
    hold_flag_i = 3'd0;
    for (int k = 0; k < 10; k++) begin
      step();
      case (m_addr)
        32'h20: check_dec("addi", 5'd2, 5'd0, 32'd2, 32'd5, 1'b1, 5'd1);
        32'h24: check_dec("add", 5'd1, 5'd2, 32'd1, 32'd2, 1'b1, 5'd3);
        32'h28: check_dec("beq", 5'd1, 5'd2, 32'd1, 32'd2, 1'b0, 5'd0);
        32'h2C: check_dec("lui", 5'd0, 5'd0, 32'h1234_5000, 32'h0, 1'b1, 5'd1);
        32'h30: check_dec("addi_x0", 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        32'h34: check_dec("jal", 5'd0, 5'd0, 32'h34, 32'd4, 1'b1, 5'd1);
        32'h38: check_dec("unknown", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        default: ;
      endcase
    end

    hold_flag_i = 3'd1; jump_flag_i = 1'b1; jump_addr_i = 32'h4;
    step();
    check_val("jump_hold_pc", pc_o, 32'h4);
    check_val("jump_hold_inst", inst_o, NOP);
    hold_flag_i = 3'd0; jump_flag_i = 1'b0;
    step();
    check_val("after_jump_inst", inst_o, rom[1]);

    jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_flag_i = 1'b0;
    step();
    check_val("wrap_pc", pc_o, 32'h0);

    for (int k = 0; k < 30; k++) begin
      hold_flag_i = 3'($urandom_range(0, 4));
      jump_flag_i = ($urandom_range(0, 3) == 0);
      jump_addr_i = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      step();
    end

    jump_flag_i = 1'b1; jump_addr_i = 32'h80; hold_flag_i = 3'd1;
    start_i = 32'h100;
    rst = 1'b1;
    #1;
    check_val("async_rst_pc", pc_o, 32'h100);
    check_val("async_rst_inst", inst_o, NOP);
    check_val("async_rst_addr", inst_addr_o, 32'h0);
    check_val("async_rst_we", {31'b0, reg_we_o}, 32'h0);
    @(posedge clk);
    #1;
    check_val("rst_over_jump_pc", pc_o, 32'h100);
    jump_flag_i = 1'b0; hold_flag_i = 3'd0;
    rst = 1'b0;
    model_reset(32'h100);
    step();
    check_val("boot_pc", pc_o, 32'h104);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameters: RESET_INST, default 32'h00000013 (addi x0,x0,0), NOP/bubble word; XLEN, default 32, datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  32  boot address, static strap, stable during and after reset.
REQ-005 jump_flag_i  input  1  1 = redirect PC.
REQ-006 jump_addr_i  input  32  redirect target.
REQ-007 hold_flag_i  input  3  stall code: 0 NONE, 1 HOLD_PC, 2 HOLD_IF, 3 HOLD_ID.
REQ-008 pc_o  output  32  fetch address to instruction ROM.
REQ-009 rom_inst_i  input  32  instruction word; ROM read is combinational from pc_o.
REQ-010 inst_o, inst_addr_o  output  32 each  IF/ID-registered instruction and its address.
REQ-011 reg1_raddr_o, reg2_raddr_o  output  5 each  register-file read addresses.
REQ-012 reg1_rdata_i, reg2_rdata_i  input  32 each  combinational register-file read data.
REQ-013 op1_o, op2_o  output  32 each  decoded operands.
REQ-014 reg_we_o  output  1  writeback enable; reg_waddr_o  output  5  destination register.

Function
REQ-015 PC next-state priority: jump_flag_i=1 -> jump_addr_i; else hold_flag_i>=1 -> unchanged; else pc+4, wrapping modulo 2^32.
REQ-016 IF/ID register priority: jump_flag_i=1 or hold_flag_i>=2 -> load RESET_INST, address 0 (bubble); else hold_flag_i=1 -> keep contents; else load rom_inst_i and pc_o.
REQ-017 Latency: instruction fetched at pc_o in cycle n appears on inst_o/inst_addr_o and decode outputs in cycle n+1.
REQ-018 Decode purely combinational from IF/ID outputs; reg1_raddr_o=inst[19:15], reg2_raddr_o=inst[24:20] when the format uses them, else 0.
REQ-019 OP-IMM/LOAD: op1=rs1 data, op2=sign-extended I-imm; we=1 (LOAD, OP-IMM).
REQ-020 OP: op1=rs1 data, op2=rs2 data, we=1.
REQ-021 STORE: op1=rs1 data, op2=sign-extended S-imm, we=0; BRANCH: op1=rs1, op2=rs2 data, we=0.
REQ-022 LUI: op1={imm[31:12],12'b0}, op2=0, we=1; AUIPC: op1=inst_addr, op2=U-imm, we=1.
REQ-023 JAL/JALR: op1=inst_addr, op2=4, we=1 (link value operands).
REQ-024 reg_waddr_o=inst[11:7] when we; rd=0 forces reg_we_o=0.
REQ-025 Unknown opcode: all decode outputs 0, reg_we_o=0.
REQ-026 Simultaneous jump and any hold: jump wins for both PC and IF/ID.

Reset
REQ-027 While rst=1: pc_o=start_i, inst_o=RESET_INST, inst_addr_o=0, all decode outputs 0.
REQ-028 First rising edge after rst falls: PC advances to start_i+4, IF/ID captures word at start_i.
REQ-029 Reset asserted mid-operation overrides jump and hold immediately (asynchronous).

Structure
REQ-030 Shared package (defines): RST level, JUMP_YES/NO, HOLD_* codes, NOP word, ZERO_WORD, RV32I opcode/funct constants, bus widths.
REQ-031 One generic sub-module gen_dff (width parameter, async reset value, enable) instantiated for PC and IF/ID registers; decode as combinational logic in the top.

Verification
REQ-032 Reset with start_i=0 -> pc_o=0, inst_o=0x00000013; release -> pc_o 4, 8, 12 on successive edges.
REQ-033 hold_flag_i=1 at pc_o=0x10 -> pc_o stays 0x10, inst_o unchanged; release -> 0x14.
REQ-034 hold=1 and jump_flag_i=1, jump_addr_i=4 same cycle -> next pc_o=4, inst_o=0x00000013, then word at 4.
REQ-035 inst 0x00510093 (addi x1,x2,5), reg1_rdata_i=2 -> raddr1=2, op1=2, op2=5, we=1, waddr=1.
REQ-036 inst 0x002081B3 (add x3,x1,x2), rdata1=1, rdata2=2 -> op1=1, op2=2, we=1, waddr=3; 0x00208463 (beq) -> we=0.
REQ-037 inst 0x123450B7 (lui x1) -> op1=0x12345000, op2=0, we=1; 0xFFF00013 (addi x0) -> op2=0xFFFFFFFF, we=0.
